// File: rtl/node_arb_pkg.sv
// Shared state encoding and default sizes for the node-share arbiter.
package node_arb_pkg;

    localparam int unsigned DefNReq = 4;
    localparam int unsigned DefW    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitLow,
        StWaitHigh,
        StDone
    } arb_state_e;

endpackage

// File: rtl/node_rr_pick.sv
// Round-robin winner search: first asserted request after the pointer, wrapping modulo NREQ.
module node_rr_pick
    import node_arb_pkg::*;
#(
    parameter int unsigned NREQ = DefNReq,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    // Scan from the farthest candidate down to ptr+1 so the nearest one is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % int'(NREQ)]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + k) % int'(NREQ));
            end
        end
    end

endmodule

// File: rtl/node_share_arbiter.sv
// Shares one start/ready evaluation node between NREQ requesters with round-robin
// arbitration, a wait timeout and a one-cycle ACK carrying the captured result.
module node_share_arbiter
    import node_arb_pkg::*;
#(
    parameter int unsigned NREQ    = DefNReq,
    parameter int unsigned W       = DefW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] a_in_i,
    input  logic [NREQ*W-1:0] b_in_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [W-1:0]      res_out_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              n_st_o,
    output logic [W-1:0]      n_in0_o,
    output logic [W-1:0]      n_in1_o,
    input  logic              n_rd_i,
    input  logic [W-1:0]      n_res_i
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] PtrRst  = IW'(NREQ - 1);
    localparam logic [CW-1:0] TmoLast = CW'(TIMEOUT - 1);

    arb_state_e      state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gnt_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] ack_q;
    logic            err_q;
    logic            busy_q;
    logic            n_st_q;
    logic [W-1:0]    n_in0_q;
    logic [W-1:0]    n_in1_q;
    logic [W-1:0]    res_q;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            wait_st;
    logic            node_done;
    logic            tmo_hit;
    logic            fin;

    node_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // A valid result in WAIT_HIGH wins over a timeout landing on the same cycle.
    always_comb begin
        wait_st   = (state_q == StWaitLow) || (state_q == StWaitHigh);
        node_done = (state_q == StWaitHigh) && n_rd_i;
        tmo_hit   = wait_st && (cnt_q == TmoLast);
        fin       = node_done || tmo_hit;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            ptr_q   <= PtrRst;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            n_st_q  <= 1'b0;
            n_in0_q <= '0;
            n_in1_q <= '0;
            res_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid && n_rd_i) begin
                        gnt_q   <= pick_idx;
                        n_in0_q <= a_in_i[pick_idx*W +: W];
                        n_in1_q <= b_in_i[pick_idx*W +: W];
                        n_st_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StLaunch;
                    end
                end
                StLaunch: begin
                    cnt_q   <= '0;
                    state_q <= StWaitLow;
                end
                StWaitLow, StWaitHigh: begin
                    if (fin) begin
                        if (node_done) begin
                            res_q <= n_res_i;
                        end
                        err_q   <= !node_done;
                        ack_q   <= NREQ'(1) << gnt_q;
                        ptr_q   <= gnt_q;
                        n_st_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (state_q == StWaitLow && !n_rd_i) begin
                            state_q <= StWaitHigh;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign n_st_o    = n_st_q;
    assign n_in0_o   = n_in0_q;
    assign n_in1_o   = n_in1_q;
    assign res_out_o = res_q;

endmodule

// File: tb/tb_node_share_arbiter.sv
// Bench for node_share_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and node delays.
module tb_node_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;
    localparam int          TMO  = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      res_out;
    logic              err;
    logic              busy;
    logic              n_st;
    logic [W-1:0]      n_in0;
    logic [W-1:0]      n_in1;
    logic              n_rd;
    logic [W-1:0]      n_res;

    always #5 CLK = ~CLK;

    node_share_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_i     (req),
        .a_in_i    (a_in),
        .b_in_i    (b_in),
        .ack_o     (ack),
        .res_out_o (res_out),
        .err_o     (err),
        .busy_o    (busy),
        .n_st_o    (n_st),
        .n_in0_o   (n_in0),
        .n_in1_o   (n_in1),
        .n_rd_i    (n_rd),
        .n_res_i   (n_res)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail_print = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Node model: mode 0 compliant (low at +2, high at +3 after ST rise), 1 random delays
    // with occasional hang, 2 never drops RD. func 0 returns IN0, 1 returns IN0+IN1.
    int   nd_mode = 0;
    int   nd_func = 0;
    int   nd_t = 0;
    int   nd_lo = 0;
    int   nd_hi = 0;
    bit   nd_act = 0;
    logic nd_st_prev = 1'b0;

    initial begin
        n_rd  = 1'b1;
        n_res = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (n_st && !nd_st_prev) begin
                nd_act = 1;
                nd_t   = 0;
                if (nd_mode == 0) begin
                    nd_lo = 2;
                    nd_hi = 3;
                end else if (nd_mode == 2 || $urandom_range(0, 7) == 0) begin
                    nd_lo = 1000000;
                    nd_hi = 1000001;
                end else begin
                    nd_lo = int'($urandom_range(1, 4));
                    nd_hi = nd_lo + int'($urandom_range(1, 5));
                end
            end else if (nd_act) begin
                nd_t++;
            end
            nd_st_prev = n_st;
            if (nd_act) begin
                n_res = 16'($urandom);
                if (nd_t == nd_lo) n_rd = 1'b0;
                if (nd_t == nd_hi) begin
                    n_rd   = 1'b1;
                    n_res  = (nd_func == 0) ? n_in0 : n_in0 + n_in1;
                    nd_act = 0;
                end
            end
        end
    end

    // Reference model. m_k: -1 no transaction, 0 launch cycle, j>=1 j-th wait cycle,
    // -2 acknowledge cycle. e_* are the outputs required during the following cycle.
    bit              m_init = 0;
    int              m_k = -1;
    int              m_ptr = NREQ - 1;
    int              m_gnt = 0;
    bit              m_low = 0;
    int              m_log[$];
    logic [NREQ-1:0] e_ack;
    logic            e_err, e_busy, e_st;
    logic [W-1:0]    e_in0, e_in1, e_res;

    initial forever begin
        @(posedge CLK);
        if (RST) begin
            m_init = 1;
            m_k    = -1;
            m_ptr  = NREQ - 1;
            e_ack  = '0;
            e_err  = 0;
            e_busy = 0;
            e_st   = 0;
            e_in0  = '0;
            e_in1  = '0;
            e_res  = '0;
        end else if (m_init) begin
            bit done_ok;
            bit done_err;
            done_ok  = 0;
            done_err = 0;
            e_ack = '0;
            e_err = 0;
            if (m_k == -1) begin
                if (n_rd && req != '0) begin
                    for (int k = 1; k <= int'(NREQ); k++) begin
                        int j;
                        j = (m_ptr + k) % int'(NREQ);
                        if (req[j]) begin
                            m_gnt = j;
                            break;
                        end
                    end
                    e_in0  = a_in[m_gnt*W +: W];
                    e_in1  = b_in[m_gnt*W +: W];
                    e_st   = 1;
                    e_busy = 1;
                    m_k    = 0;
                    m_low  = 0;
                end
            end else if (m_k == -2) begin
                e_busy = 0;
                m_k    = -1;
            end else begin
                if (m_k >= 1 && m_low && n_rd) done_ok = 1;
                else if (m_k >= TMO) done_err = 1;
                else begin
                    if (m_k >= 1 && !n_rd) m_low = 1;
                    m_k++;
                end
                if (done_ok || done_err) begin
                    if (done_ok) e_res = n_res;
                    e_err        = done_err;
                    e_ack[m_gnt] = 1'b1;
                    e_st         = 0;
                    m_ptr        = m_gnt;
                    m_k          = -2;
                    m_log.push_back(m_gnt);
                end
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (m_init) begin
            n_chk++;
            if ({ack, err, busy, n_st, n_in0, n_in1, res_out} ===
                {e_ack, e_err, e_busy, e_st, e_in0, e_in1, e_res}) begin
                n_pass++;
            end else if (n_fail_print < 20) begin
                n_fail_print++;
                $display("FAIL cycle_cmp cyc=%0d (got/exp) ack=%b/%b err=%b/%b busy=%b/%b st=%b/%b in0=%h/%h in1=%h/%h res=%h/%h",
                         cyc, ack, e_ack, err, e_err, busy, e_busy, n_st, e_st,
                         n_in0, e_in0, n_in1, e_in1, res_out, e_res);
            end
        end
    end

    task automatic wait_ack(input int limit, output int idx, output int lat);
        idx = -1;
        lat = 0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge CLK);
            if (ack != '0) begin
                lat = n;
                for (int i = 0; i < int'(NREQ); i++) if (ack[i]) idx = i;
                break;
            end
        end
        if (idx < 0) begin
            n_chk++;
            $display("FAIL ack_wait: no ACK within %0d cycles, one required", limit);
        end
    endtask

    task automatic do_reset(input logic [NREQ-1:0] r);
        RST = 1'b1;
        req = r;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    logic [W-1:0] a_val [NREQ];
    int exp_ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        int idx, lat, prev_cyc, extra;
        RST  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < int'(NREQ); i++) a_val[i] = 16'(16'hA000 + i * 16'h0111);
        repeat (3) @(negedge CLK);
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_nst", 64'(n_st), 64'(0));
        chk("rst_res", 64'(res_out), 64'(0));
        chk("rst_in0", 64'(n_in0), 64'(0));
        RST = 1'b0;

        // Single request
        a_in[1*W +: W] = 16'h1234;
        b_in[1*W +: W] = 16'h5678;
        req = 4'b0010;
        wait_ack(20, idx, lat);
        req = '0;
        chk("single_idx", 64'(idx), 64'(1));
        chk("single_lat", 64'(lat), 64'(5));
        chk("single_res", 64'(res_out), 64'(16'h1234));
        chk("single_err", 64'(err), 64'(0));

        // Contention from reset
        for (int i = 0; i < int'(NREQ); i++) a_in[i*W +: W] = a_val[i];
        do_reset(4'b1111);
        m_log.delete();
        prev_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(20, idx, lat);
            chk($sformatf("cont_idx%0d", k), 64'(idx), 64'(exp_ord[k]));
            chk($sformatf("cont_res%0d", k), 64'(res_out), 64'(a_val[exp_ord[k]]));
            if (k > 0) chk($sformatf("cont_gap%0d", k), 64'(cyc - prev_cyc), 64'(6));
            prev_cyc = cyc;
        end
        req = '0;
        chk("model_log_n", 64'(m_log.size()), 64'(5));
        for (int k = 0; k < 5 && k < m_log.size(); k++)
            chk($sformatf("model_log%0d", k), 64'(m_log[k]), 64'(exp_ord[k]));

        // Fairness
        do_reset('0);
        req = 4'b0001;
        repeat (2) @(negedge CLK);
        req[2] = 1'b1;
        wait_ack(20, idx, lat);
        chk("fair_first", 64'(idx), 64'(0));
        wait_ack(20, idx, lat);
        chk("fair_second", 64'(idx), 64'(2));
        req = '0;
        @(negedge CLK);

        // Timeout with a node that never drops RD
        nd_mode = 2;
        req = 4'b0010;
        wait_ack(30, idx, lat);
        req = '0;
        chk("tmo_idx", 64'(idx), 64'(1));
        chk("tmo_lat", 64'(lat), 64'(10));
        chk("tmo_err", 64'(err), 64'(1));
        chk("tmo_res_kept", 64'(res_out), 64'(a_val[2]));
        @(negedge CLK);
        nd_mode = 0;
        req = 4'b1000;
        wait_ack(20, idx, lat);
        req = '0;
        chk("post_tmo_idx", 64'(idx), 64'(3));
        chk("post_tmo_lat", 64'(lat), 64'(5));
        chk("post_tmo_err", 64'(err), 64'(0));
        chk("post_tmo_res", 64'(res_out), 64'(a_val[3]));
        @(negedge CLK);

        // Reset during WAIT_HIGH
        req = 4'b0001;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        req = '0;
        @(negedge CLK);
        chk("midrst_nst", 64'(n_st), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_ack", 64'(ack), 64'(0));
        RST = 1'b0;
        req = 4'b1111;
        wait_ack(20, idx, lat);
        req = '0;
        chk("midrst_prio", 64'(idx), 64'(0));
        @(negedge CLK);

        // Request dropped during LAUNCH
        req = 4'b1000;
        @(negedge CLK);
        req = '0;
        wait_ack(20, idx, lat);
        chk("late_idx", 64'(idx), 64'(3));
        chk("late_lat", 64'(lat), 64'(4));
        extra = 0;
        repeat (15) begin
            @(negedge CLK);
            if (ack != '0) extra++;
        end
        chk("late_no_regrant", 64'(extra), 64'(0));

        // Randomized traffic against the reference model
        nd_mode = 1;
        nd_func = 1;
        repeat (1500) begin
            @(negedge CLK);
            a_in = {$urandom, $urandom};
            b_in = {$urandom, $urandom};
            for (int i = 0; i < int'(NREQ); i++) begin
                if (ack[i]) req[i] = 1'($urandom_range(0, 1));
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
        end
        req = '0;
        repeat (40) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/node_share_arbiter.md
# node_share_arbiter

Round-robin arbiter that shares one two-operand evaluation node (ST/RD/RES start-ready handshake) between NREQ requesters. It selects one pending requester and drives that requester's operands onto the node inputs. It then runs the node's start/ready handshake, captures the result and returns it to the requester with a one-cycle ACK. It sits between the tree-evaluation front end and a single expensive node instance, so the node is instantiated once instead of per consumer.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- W, 16, operand/result width
- TIMEOUT, 255, max cycles spent waiting on node RD transitions before abort

Ports. Reset is RST, synchronous, active-high; clock is CLK.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ  in  NREQ  per-requester request level, held until ACK
- A_IN  in  NREQ*W  operand 0, slice i = requester i
- B_IN  in  NREQ*W  operand 1, slice i = requester i
- ACK  out  NREQ  one-hot, one-cycle pulse, result/ERR valid
- RES_OUT  out  W  result, valid with ACK, held until next ACK
- ERR  out  1  pulses with ACK when the transaction timed out
- BUSY  out  1  high from LAUNCH through DONE
- N_ST  out  1  node start level; node acts on its rising edge
- N_IN0  out  W  node operand 0
- N_IN1  out  W  node operand 1
- N_RD  in  1  node ready; high = idle or result valid
- N_RES  in  W  node result

## Operation
- States: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE: if any REQ and N_RD=1, pick the winner, register its index into GNT, latch its A/B slices into N_IN0/N_IN1 → LAUNCH. If N_RD=0, stay in IDLE.
- LAUNCH: N_ST=1 → WAIT_LOW.
- WAIT_LOW: N_ST=1; on N_RD=0 → WAIT_HIGH.
- WAIT_HIGH: N_ST=1; on N_RD=1, RES_OUT<=N_RES → DONE.
- DONE: N_ST=0, ACK[GNT]=1 → IDLE.
- Timeout: a counter clears on entry to WAIT_LOW and runs through WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT → DONE with ERR=1 and RES_OUT unchanged.
- Round-robin: pointer PTR holds the last granted index. The winner is the first asserted REQ searching PTR+1, PTR+2, … modulo NREQ. PTR<=GNT on entry to DONE.
- REQ is sampled only in IDLE. Deassertion after grant is ignored; the transaction completes and ACK still pulses. A REQ still high in the cycle after ACK is treated as a new request.
- Operands (N_IN0/N_IN1) are stable from LAUNCH through DONE. Changes on A_IN/B_IN after grant have no effect.
- Reset values: N_ST=0, N_IN0=N_IN1=0, RES_OUT=0, ACK=0, ERR=0, BUSY=0, state IDLE, PTR=NREQ-1 (requester 0 wins first), counter 0.
- Reset mid-transaction: return to IDLE with reset values; no ACK is issued for the aborted request.

## Timing
- For a compliant node, N_RD is low 2 cycles after the ST rise and high again 3 cycles after it.
- REQ sampled in IDLE at cycle 0 → LAUNCH cycle 1 → WAIT_LOW cycles 2–3 → N_RD=1 seen in cycle 4 → ACK in cycle 5.
- Latency is 5 cycles. Best-case throughput is one transaction per 6 cycles (IDLE, LAUNCH, 3 wait cycles, DONE).
- N_ST is low for at least 2 cycles (DONE, IDLE) between starts, so every launch is a clean rising edge.
- ACK and ERR are registered, never combinational from REQ.
- Simultaneous REQs are resolved purely by PTR. A grant never goes to the same requester twice in a row while another REQ is pending in IDLE.

## Structure
- Shared package node_arb_pkg: state enum (IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, DONE) and default widths W=16, NREQ=4.
- Sub-module node_rr_pick, combinational: inputs REQ and PTR; outputs VALID and IDX. One instance, parameterised on NREQ.
- Operand mux, FSM, timeout counter and output registers live in the top module.

## Test plan
- Single request: REQ=0010, A_IN[1]=0x1234, B_IN[1]=0x5678, node model returns IN0 → ACK=0010 at cycle 5, RES_OUT=0x1234, ERR=0.
- Contention: REQ=1111 held continuously from reset → grants in order 0,1,2,3,0; ACKs spaced 6 cycles apart; each RES_OUT equals that requester's A slice.
- Fairness: REQ[0] held, REQ[2] raised during requester 0's transaction → the next grant is 2, not 0.
- Timeout: node model holds N_RD=1 forever, TIMEOUT=8 → ACK pulses with ERR=1 after 8 wait cycles; RES_OUT unchanged; the next request proceeds normally.
- Reset mid-operation: assert RST in WAIT_HIGH → next cycle N_ST=0, BUSY=0, ACK=0, and requester 0 has priority again.
- Late drop: REQ[3] deasserted in LAUNCH → transaction completes, ACK[3] pulses, no further grant to 3.
